hazard_stall_ctrl: RTL and testbench

//   Stall and flush controller for the 5-stage MIPS pipeline. It is the counterpart of operand

---
 rtl/hazard_stall_ctrl.sv | 94 +++++++++
 tb/tb_hazard_stall_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller for a 5-stage MIPS pipeline: detects load-use and ID-stage branch
// hazards, redirects taken branches, freezes on memory busy, and counts stall/flush cycles.
module hazard_stall_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       ID_Rs,
    input  logic [4:0]       ID_Rt,
    input  logic             ID_UsesRt,
    input  logic             ID_IsBranch,
    input  logic             ID_BranchTaken,
    input  logic             ID_Ex_MemRead,
    input  logic             ID_Ex_Regwrite,
    input  logic [4:0]       ID_Ex_WriteReg,
    input  logic             Ex_Mem_MemRead,
    input  logic [4:0]       Ex_Mem_WriteReg,
    input  logic             Mem_Busy,
    output logic             PC_write,
    output logic             IF_ID_write,
    output logic             ID_Ex_bubble,
    output logic             IF_ID_flush,
    output logic             Pipe_freeze,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic {
        S_RUN   = 1'b0,
        S_HOLD1 = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    logic match_ex, match_mem;
    logic h_lu, h_ba, h_bl2, h_bl1, hazard;

    // $0 is never a real producer, so it can never create a dependence.
    assign match_ex  = (ID_Ex_WriteReg != 5'd0) &&
                       ((ID_Ex_WriteReg == ID_Rs) || (ID_UsesRt && (ID_Ex_WriteReg == ID_Rt)));
    assign match_mem = (Ex_Mem_WriteReg != 5'd0) &&
                       ((Ex_Mem_WriteReg == ID_Rs) || (ID_UsesRt && (Ex_Mem_WriteReg == ID_Rt)));

    assign h_lu   = ID_Ex_MemRead && match_ex;
    assign h_ba   = ID_IsBranch && ID_Ex_Regwrite && !ID_Ex_MemRead && match_ex;
    assign h_bl2  = ID_IsBranch && ID_Ex_MemRead && match_ex;
    assign h_bl1  = ID_IsBranch && Ex_Mem_MemRead && match_mem;
    assign hazard = h_lu || h_ba || h_bl2 || h_bl1;

    // Outputs must react in the same cycle as the hazard, so they are decoded combinationally.
    always_comb begin
        state_d      = state_q;
        PC_write     = 1'b0;
        IF_ID_write  = 1'b0;
        ID_Ex_bubble = 1'b0;
        IF_ID_flush  = 1'b0;
        Pipe_freeze  = 1'b0;
        if (!rst_n) begin
            ID_Ex_bubble = 1'b1;
            state_d      = S_RUN;
        end else if (Mem_Busy) begin
            Pipe_freeze = 1'b1;
        end else if (state_q == S_HOLD1) begin
            ID_Ex_bubble = 1'b1;
            state_d      = S_RUN;
        end else if (hazard) begin
            ID_Ex_bubble = 1'b1;
            state_d      = h_bl2 ? S_HOLD1 : S_RUN;
        end else begin
            PC_write    = 1'b1;
            IF_ID_write = 1'b1;
            IF_ID_flush = ID_IsBranch && ID_BranchTaken;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (ID_Ex_bubble && (stall_cnt_q != {CNT_W{1'b1}}))
                stall_cnt_q <= stall_cnt_q + 1'b1;
            if (IF_ID_flush && (flush_cnt_q != {CNT_W{1'b1}}))
                flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: hazard classes, HOLD1 sequencing, freeze, reset, saturation.
module tb_hazard_stall_ctrl;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [4:0]    ID_Rs, ID_Rt, ID_Ex_WriteReg, Ex_Mem_WriteReg;
    logic          ID_UsesRt, ID_IsBranch, ID_BranchTaken;
    logic          ID_Ex_MemRead, ID_Ex_Regwrite, Ex_Mem_MemRead, Mem_Busy;
    logic          PC_write, IF_ID_write, ID_Ex_bubble, IF_ID_flush, Pipe_freeze;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int tests = 0;
    int fails = 0;

    // Control vector order: {PC_write, IF_ID_write, ID_Ex_bubble, IF_ID_flush, Pipe_freeze}
    localparam logic [4:0] C_RUN    = 5'b11000;
    localparam logic [4:0] C_STALL  = 5'b00100;
    localparam logic [4:0] C_FLUSH  = 5'b11010;
    localparam logic [4:0] C_FREEZE = 5'b00001;
    localparam logic [4:0] C_RESET  = 5'b00100;

    hazard_stall_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
        .ID_IsBranch(ID_IsBranch), .ID_BranchTaken(ID_BranchTaken),
        .ID_Ex_MemRead(ID_Ex_MemRead), .ID_Ex_Regwrite(ID_Ex_Regwrite),
        .ID_Ex_WriteReg(ID_Ex_WriteReg), .Ex_Mem_MemRead(Ex_Mem_MemRead),
        .Ex_Mem_WriteReg(Ex_Mem_WriteReg), .Mem_Busy(Mem_Busy),
        .PC_write(PC_write), .IF_ID_write(IF_ID_write), .ID_Ex_bubble(ID_Ex_bubble),
        .IF_ID_flush(IF_ID_flush), .Pipe_freeze(Pipe_freeze),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctrl(input string tag, input logic [4:0] exp);
        #1;
        chk(tag, {27'd0, PC_write, IF_ID_write, ID_Ex_bubble, IF_ID_flush, Pipe_freeze},
            {27'd0, exp});
        $display("[TB] %s ctrl=%b stall_cnt=%0d flush_cnt=%0d", tag,
                 {PC_write, IF_ID_write, ID_Ex_bubble, IF_ID_flush, Pipe_freeze},
                 stall_cnt, flush_cnt);
    endtask

    task automatic chk_cnt(input string tag, input int s, input int f);
        chk({tag, ".stall"}, {28'd0, stall_cnt}, s);
        chk({tag, ".flush"}, {28'd0, flush_cnt}, f);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ID_Rs = 0; ID_Rt = 0; ID_UsesRt = 0; ID_IsBranch = 0; ID_BranchTaken = 0;
        ID_Ex_MemRead = 0; ID_Ex_Regwrite = 0; ID_Ex_WriteReg = 0;
        Ex_Mem_MemRead = 0; Ex_Mem_WriteReg = 0; Mem_Busy = 0;
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        #2;
        chk_ctrl("reset_outputs", C_RESET);
        chk_cnt("reset", 0, 0);
        tick(); tick();
        rst_n = 1'b1;
        chk_ctrl("run_idle", C_RUN);

        // Load-use on rs
        ID_Ex_MemRead = 1; ID_Ex_WriteReg = 8; ID_Rs = 8;
        chk_ctrl("lu_rs", C_STALL);
        chk_cnt("lu_rs_pre", 0, 0);
        tick();
        chk_cnt("lu_rs_post", 1, 0);
        clear_inputs();
        chk_ctrl("lu_rs_after", C_RUN);
        tick();

        // Load-use on rt, gated by ID_UsesRt
        ID_Ex_MemRead = 1; ID_Ex_WriteReg = 8; ID_Rt = 8; ID_UsesRt = 0;
        chk_ctrl("lu_rt_unused", C_RUN);
        tick();
        ID_UsesRt = 1;
        chk_ctrl("lu_rt_used", C_STALL);
        tick();
        chk_cnt("lu_rt", 2, 0);

        // Writes to $0 never match
        clear_inputs();
        ID_Ex_MemRead = 1; ID_Ex_WriteReg = 0; ID_Rs = 0;
        chk_ctrl("lu_r0", C_RUN);
        tick();

        // Branch after ALU op: one stall, stays in RUN
        clear_inputs();
        ID_IsBranch = 1; ID_Rs = 5; ID_Ex_Regwrite = 1; ID_Ex_WriteReg = 5;
        chk_ctrl("h_ba", C_STALL);
        tick();
        ID_Ex_Regwrite = 0; ID_Ex_WriteReg = 0;
        chk_ctrl("h_ba_done", C_RUN);
        tick();

        // Branch two behind a load
        clear_inputs();
        ID_IsBranch = 1; ID_Rs = 5; Ex_Mem_MemRead = 1; Ex_Mem_WriteReg = 5;
        chk_ctrl("h_bl1", C_STALL);
        tick();
        chk_cnt("h_bl1", 4, 0);
        ID_IsBranch = 0;
        chk_ctrl("mem_load_nonbranch", C_RUN);
        tick();

        // Asynchronous reset mid-cycle clears counters immediately
        clear_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        chk_cnt("async_rst", 0, 0);
        tick();
        rst_n = 1'b1;

        // beq $9,$10 behind load $9: two stalls, then taken-branch flush
        ID_IsBranch = 1; ID_BranchTaken = 1; ID_Rs = 9; ID_Rt = 10; ID_UsesRt = 1;
        ID_Ex_MemRead = 1; ID_Ex_Regwrite = 1; ID_Ex_WriteReg = 9;
        chk_ctrl("bl2_c1", C_STALL);
        tick();
        ID_Ex_MemRead = 0; ID_Ex_Regwrite = 0; ID_Ex_WriteReg = 0;
        Ex_Mem_MemRead = 1; Ex_Mem_WriteReg = 9;
        chk_ctrl("bl2_c2", C_STALL);
        tick();
        Ex_Mem_MemRead = 0; Ex_Mem_WriteReg = 0;
        chk_ctrl("bl2_flush", C_FLUSH);
        tick();
        chk_cnt("bl2", 2, 1);

        // Mem_Busy during HOLD1: freeze holds state and counters
        clear_inputs();
        ID_IsBranch = 1; ID_Rs = 9; ID_Ex_MemRead = 1; ID_Ex_WriteReg = 9;
        chk_ctrl("busy_enter", C_STALL);
        tick();
        clear_inputs();
        ID_IsBranch = 1; Mem_Busy = 1;
        for (int i = 0; i < 3; i++) begin
            chk_ctrl($sformatf("busy_freeze%0d", i), C_FREEZE);
            tick();
        end
        chk_cnt("busy_hold", 3, 1);
        Mem_Busy = 0;
        chk_ctrl("busy_hold1_stall", C_STALL);
        tick();
        chk_ctrl("busy_back_run", C_RUN);
        chk_cnt("busy_done", 4, 1);
        tick();

        // Freeze overrides a hazard and a taken branch in RUN
        ID_IsBranch = 1; ID_BranchTaken = 1; Mem_Busy = 1;
        ID_Rs = 3; ID_Ex_MemRead = 1; ID_Ex_WriteReg = 3;
        chk_ctrl("busy_run", C_FREEZE);
        tick();
        chk_cnt("busy_run", 4, 1);

        // Reset during HOLD1 returns to RUN
        clear_inputs();
        ID_IsBranch = 1; ID_Rs = 7; ID_Ex_MemRead = 1; ID_Ex_WriteReg = 7;
        chk_ctrl("rst_hold_enter", C_STALL);
        tick();
        clear_inputs();
        rst_n = 1'b0;
        chk_ctrl("rst_hold_outputs", C_RESET);
        chk_cnt("rst_hold", 0, 0);
        tick();
        rst_n = 1'b1;
        chk_ctrl("rst_hold_run", C_RUN);
        tick();

        // Saturation: 20 stall cycles on a 4-bit counter
        ID_Rs = 4; ID_Ex_MemRead = 1; ID_Ex_WriteReg = 4;
        for (int i = 0; i < 20; i++) begin
            chk_ctrl($sformatf("sat_stall%0d", i), C_STALL);
            tick();
        end
        chk_cnt("sat", 15, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
